restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 109 ++++++++++
 tb/tb_restoring_divider.sv | 109 ++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle restoring divider (IDLE/LOAD/RUN/FIX/DONE), latency WIDTH+3; `define DIVIDER_SIGNED_EN for two's-complement mode
// Ports: clk, rst (sync, active-high), start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, shf, dif;
  logic [WIDTH-1:0] acc_q, acc_d, dnd_q, dnd_d, dvs_q, dvs_d, dvm_q, dvm_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d, mag_a, mag_b, q_fix, r_fix;
  logic dbz_q, dbz_d, sa, sb, dz;
`ifdef DIVIDER_SIGNED_EN
  assign sa = dnd_q[WIDTH-1];
  assign sb = dvs_q[WIDTH-1];
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  assign mag_a = sa ? -dnd_q : dnd_q;
  assign mag_b = sb ? -dvs_q : dvs_q;
  assign shf   = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign dif   = shf - {1'b0, dvm_q};
  assign q_fix = (sa ^ sb) ? -acc_q : acc_q;
  assign r_fix = sa ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign dz    = dvs_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dnd_d   = dnd_q;
    dvs_d   = dvs_q;
    dvm_d   = dvm_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        dnd_d   = dividend;
        dvs_d   = divisor;
      end
      LOAD: begin
        acc_d   = mag_a;
        dvm_d   = mag_b;
        rem_d   = '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = RUN;
      end
      RUN: begin
        // negative trial difference (MSB set) means restore the shifted remainder
        rem_d   = dif[WIDTH] ? shf : dif;
        acc_d   = {acc_q[WIDTH-2:0], ~dif[WIDTH]};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? FIX : RUN;
      end
      FIX: begin
        dbz_d   = dz;
        quo_d   = dz ? '1 : q_fix;
        rmd_d   = dz ? dnd_q : r_fix;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dnd_q   <= '0;
      dvs_q   <= '0;
      dvm_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dnd_q   <= dnd_d;
      dvs_q   <= dvs_d;
      dvm_q   <= dvm_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = state_q == LOAD || state_q == RUN || state_q == FIX;
  assign done        = state_q == DONE;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed self-checking bench for restoring_divider (WIDTH=8)
module tb_restoring_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int checks = 0, failures = 0;
  restoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez, input bit poke);
    int dk, nd, nb;
    dk = 0; nd = 0; nb = 0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (poke && k == 4) begin start = 1'b1; dividend = 8'd99; divisor = 8'd5; end
      if (poke && k == 5) start = 1'b0;
      if (busy) nb++;
      if (done) begin nd++; if (dk == 0) dk = k; end
    end
    chk({tag, "_lat"}, dk, 11);
    chk({tag, "_pulses"}, nd, 1);
    chk({tag, "_busy"}, nb, 10);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, ez);
  endtask
  int nd;
  int pk[$];
  logic [7:0] eq3 [3] = '{8'd6, 8'd11, 8'd12};
  logic [7:0] er3 [3] = '{8'd2, 8'd2, 8'd8};
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
`ifdef DIVIDER_SIGNED_EN
    run_div("s200_7", 8'd200, 8'd7, 8'hF8, 8'h00, 1'b0, 1'b0);
    run_div("m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0);
    run_div("m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
`else
    run_div("u200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
    run_div("u249_2", 8'hF9, 8'd2, 8'h7C, 8'h01, 1'b0, 1'b0);
    run_div("u128_255", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0);
`endif
    run_div("dz", 8'h5A, 8'd0, 8'hFF, 8'h5A, 1'b1, 1'b0);
    run_div("ign", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b1);
    @(negedge clk);
    dividend = 8'd77; divisor = 8'd4; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    run_div("after_rst", 8'd77, 8'd4, 8'd19, 8'd1, 1'b0, 1'b0);
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        if (pk.size() < 3) begin
          chk($sformatf("hold_q%0d", pk.size()), quotient, eq3[pk.size()]);
          chk($sformatf("hold_r%0d", pk.size()), remainder, er3[pk.size()]);
        end
        pk.push_back(n);
      end
      start = n < 30;
      dividend = 8'(4 * n + 20);
      divisor = 8'(n / 4 + 3);
    end
    start = 1'b0;
    chk("hold_pulses", pk.size(), 3);
    if (pk.size() == 3) begin
      chk("hold_first", pk[0], 11);
      chk("hold_gap1", pk[1] - pk[0], 12);
      chk("hold_gap2", pk[2] - pk[1], 12);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
